// File: rtl/soc_region_table.sv
// ============================================================================
// Module   : soc_region_table
// Brief    : Runtime-programmable address-region table with pipelined lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_region_table #(
   parameter int unsigned          NrRules   = 8,
   parameter int unsigned          AddrWidth = 64,
   parameter logic [AddrWidth-1:0] RstBase   = AddrWidth'(64'h8000_0000),
   parameter logic [AddrWidth-1:0] RstLength = AddrWidth'(64'h4000_0000),
   parameter logic [4:0]           RstAttr   = 5'b0_1_1_1_0,
   localparam int unsigned         IdxW      = (NrRules > 1) ? $clog2(NrRules) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [IdxW+1:0]      cfg_addr_i,
   input  logic [AddrWidth-1:0] cfg_wdata_i,
   output logic                 cfg_gnt_o,
   output logic                 cfg_rvalid_o,
   output logic [AddrWidth-1:0] cfg_rdata_o,
   output logic                 cfg_err_o,
   input  logic                 lkp_valid_i,
   output logic                 lkp_ready_o,
   input  logic [AddrWidth-1:0] lkp_addr_i,
   output logic                 lkp_valid_o,
   input  logic                 lkp_ready_i,
   output logic                 lkp_hit_o,
   output logic [IdxW-1:0]      lkp_idx_o,
   output logic [3:0]           lkp_attr_o
);

   localparam int unsigned c_lock    = 4;
   localparam int unsigned c_valid   = 3;
   localparam int unsigned c_cached  = 2;
   localparam int unsigned c_exec    = 1;
   localparam int unsigned c_nonidem = 0;

   logic [AddrWidth-1:0] r_base [NrRules];
   logic [AddrWidth-1:0] r_len  [NrRules];
   logic [4:0]           r_attr [NrRules];

   logic [IdxW-1:0]      w_cfg_idx;
   logic [1:0]           w_cfg_fld;
   logic                 w_idx_ok;
   logic                 w_locked;
   logic                 w_cfg_err;
   logic                 w_cfg_wr;
   logic [AddrWidth-1:0] w_rdata;

   logic                 r_cfg_rvalid;
   logic                 r_cfg_err;
   logic [AddrWidth-1:0] r_cfg_rdata;

   logic [NrRules-1:0]   w_hit;
   logic                 w_any;
   logic [IdxW-1:0]      w_sel;
   logic [4:0]           w_sel_attr;
   logic [3:0]           w_lkp_attr;
   logic                 w_lkp_acc;

   logic                 r_lkp_valid;
   logic                 r_lkp_hit;
   logic [IdxW-1:0]      r_lkp_idx;
   logic [3:0]           r_lkp_attr;

   // ---------------------------------------------------------------- config
   assign w_cfg_idx = cfg_addr_i[IdxW+1:2];
   assign w_cfg_fld = cfg_addr_i[1:0];
   assign w_idx_ok  = (32'(w_cfg_idx) < NrRules);
   assign w_locked  = w_idx_ok && r_attr[w_cfg_idx][c_lock];
   assign w_cfg_err = !w_idx_ok || (w_cfg_fld == 2'd3) || (cfg_we_i && w_locked);
   assign w_cfg_wr  = cfg_req_i && cfg_we_i && !w_cfg_err;
   assign cfg_gnt_o = cfg_req_i;

   always_comb begin
      w_rdata = '0;
      if (w_idx_ok && !cfg_we_i) begin
         case (w_cfg_fld)
            2'd0:    w_rdata = r_base[w_cfg_idx];
            2'd1:    w_rdata = r_len[w_cfg_idx];
            2'd2:    w_rdata = AddrWidth'(r_attr[w_cfg_idx]);
            default: w_rdata = '0;
         endcase
      end
   end

   // Locked rules reject writes, so lock can only be cleared by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NrRules); i++) begin
            r_base[i] <= (i == 0) ? RstBase   : '0;
            r_len[i]  <= (i == 0) ? RstLength : '0;
            r_attr[i] <= (i == 0) ? RstAttr   : '0;
         end
      end else if (w_cfg_wr) begin
         case (w_cfg_fld)
            2'd0:    r_base[w_cfg_idx] <= cfg_wdata_i;
            2'd1:    r_len[w_cfg_idx]  <= cfg_wdata_i;
            2'd2:    r_attr[w_cfg_idx] <= cfg_wdata_i[4:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cfg_rvalid <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_cfg_rdata  <= '0;
      end else begin
         r_cfg_rvalid <= cfg_req_i;
         r_cfg_err    <= cfg_req_i && w_cfg_err;
         r_cfg_rdata  <= (cfg_req_i && !w_cfg_err) ? w_rdata : '0;
      end
   end

   assign cfg_rvalid_o = r_cfg_rvalid;
   assign cfg_err_o    = r_cfg_err;
   assign cfg_rdata_o  = r_cfg_rdata;

   // ---------------------------------------------------------------- lookup
   // Offset compare avoids overflow, so a region ending at 2^AddrWidth works.
   for (genvar g = 0; g < int'(NrRules); g++) begin : g_rule
      assign w_hit[g] = r_attr[g][c_valid] &&
                        (lkp_addr_i >= r_base[g]) &&
                        ((lkp_addr_i - r_base[g]) < r_len[g]);
   end

   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int i = int'(NrRules) - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_any = 1'b1;
            w_sel = i[IdxW-1:0];
         end
      end
   end

   assign w_sel_attr = r_attr[w_sel];
   assign w_lkp_attr = w_any ? {w_sel_attr[c_cached], w_sel_attr[c_exec],
                                w_sel_attr[c_nonidem], w_sel_attr[c_valid]} : 4'd0;

   assign lkp_ready_o = !r_lkp_valid || lkp_ready_i;
   assign w_lkp_acc   = lkp_valid_i && lkp_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lkp_valid <= 1'b0;
         r_lkp_hit   <= 1'b0;
         r_lkp_idx   <= '0;
         r_lkp_attr  <= '0;
      end else if (w_lkp_acc) begin
         r_lkp_valid <= 1'b1;
         r_lkp_hit   <= w_any;
         r_lkp_idx   <= w_sel;
         r_lkp_attr  <= w_lkp_attr;
      end else if (lkp_ready_i) begin
         r_lkp_valid <= 1'b0;
      end
   end

   assign lkp_valid_o = r_lkp_valid;
   assign lkp_hit_o   = r_lkp_hit;
   assign lkp_idx_o   = r_lkp_idx;
   assign lkp_attr_o  = r_lkp_attr;

endmodule

`default_nettype wire

// File: tb/tb_soc_region_table.sv
// ============================================================================
// Module   : tb_soc_region_table
// Brief    : Directed self-checking bench for soc_region_table (6 rules).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_region_table;

   localparam int unsigned NR   = 6;
   localparam int unsigned IDXW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_req, cfg_we;
   logic [IDXW+1:0]   cfg_addr;
   logic [63:0]       cfg_wdata;
   logic              cfg_gnt, cfg_rvalid, cfg_err;
   logic [63:0]       cfg_rdata;
   logic              lkp_valid_i, lkp_ready_o, lkp_valid_o, lkp_ready_i;
   logic [63:0]       lkp_addr;
   logic              lkp_hit;
   logic [IDXW-1:0]   lkp_idx;
   logic [3:0]        lkp_attr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   soc_region_table #(.NrRules(NR), .AddrWidth(64)) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
      .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid),
      .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
      .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_addr_i(lkp_addr),
      .lkp_valid_o(lkp_valid_o), .lkp_ready_i(lkp_ready_i), .lkp_hit_o(lkp_hit),
      .lkp_idx_o(lkp_idx), .lkp_attr_o(lkp_attr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One config access; response checked on the negedge after the grant edge.
   task automatic cfg(input string tag, input logic we, input int idx, input int fld,
                      input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_rd);
      @(negedge clk);
      cfg_req = 1'b1; cfg_we = we; cfg_addr = {idx[IDXW-1:0], fld[1:0]}; cfg_wdata = wd;
      #1 chk({tag, ".gnt"}, 64'(cfg_gnt), 64'd1);
      @(negedge clk);
      cfg_req = 1'b0; cfg_we = 1'b0;
      chk({tag, ".rvalid"}, 64'(cfg_rvalid), 64'd1);
      chk({tag, ".err"}, 64'(cfg_err), 64'(exp_err));
      if (!we || exp_err) chk({tag, ".rdata"}, cfg_rdata, exp_rd);
   endtask

   task automatic lkp(input string tag, input logic [63:0] a, input logic eh,
                      input int ei, input logic [3:0] ea);
      @(negedge clk);
      lkp_valid_i = 1'b1; lkp_addr = a; lkp_ready_i = 1'b1;
      @(negedge clk);
      lkp_valid_i = 1'b0;
      chk({tag, ".valid"}, 64'(lkp_valid_o), 64'd1);
      chk({tag, ".hit"}, 64'(lkp_hit), 64'(eh));
      chk({tag, ".idx"}, 64'(lkp_idx), 64'(ei));
      chk({tag, ".attr"}, 64'(lkp_attr), 64'(ea));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      lkp_valid_i = 1'b0; lkp_ready_i = 1'b1; lkp_addr = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst.rvalid", 64'(cfg_rvalid), 64'd0);
      chk("rst.lvalid", 64'(lkp_valid_o), 64'd0);
      chk("rst.hit", 64'(lkp_hit), 64'd0);
      chk("rst.ready", 64'(lkp_ready_o), 64'd1);

      lkp("rst.l0", 64'h8000_1000, 1'b1, 0, 4'b1101);
      lkp("rst.miss", 64'h1000_0000, 1'b0, 0, 4'b0000);
      cfg("rst.rd_len0", 1'b0, 0, 1, '0, 1'b0, 64'h4000_0000);
      @(negedge clk);
      chk("rvalid_pulse", 64'(cfg_rvalid), 64'd0);
      lkp("rst.r1_clear", 64'h0, 1'b0, 0, 4'b0000);

      // Programming and priority
      cfg("w.r1b", 1'b1, 1, 0, 64'h1000_0000, 1'b0, '0);
      cfg("w.r1l", 1'b1, 1, 1, 64'h1000, 1'b0, '0);
      cfg("w.r1a", 1'b1, 1, 2, 64'h08, 1'b0, '0);
      cfg("w.r0b", 1'b1, 0, 0, 64'h0, 1'b0, '0);
      cfg("w.r0l", 1'b1, 0, 1, 64'h2000_0000, 1'b0, '0);
      lkp("prio.both", 64'h1000_0800, 1'b1, 0, 4'b1101);
      lkp("prio.r1end", 64'h1000_1000, 1'b1, 0, 4'b1101);
      cfg("w.r0off", 1'b1, 0, 2, 64'h0, 1'b0, '0);
      lkp("prio.r0off", 64'h1000_1000, 1'b0, 0, 4'b0000);
      lkp("prio.r1only", 64'h1000_0800, 1'b1, 1, 4'b0001);

      // Top-of-space region and zero length
      cfg("w.r2b", 1'b1, 2, 0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, '0);
      cfg("w.r2l", 1'b1, 2, 1, 64'h1000, 1'b0, '0);
      cfg("w.r2a", 1'b1, 2, 2, 64'h09, 1'b0, '0);
      lkp("bnd.top", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 4'b0011);
      lkp("bnd.first", 64'hFFFF_FFFF_FFFF_F000, 1'b1, 2, 4'b0011);
      lkp("bnd.below", 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 0, 4'b0000);
      cfg("w.r4b", 1'b1, 4, 0, 64'h5000, 1'b0, '0);
      cfg("w.r4a", 1'b1, 4, 2, 64'h08, 1'b0, '0);
      lkp("bnd.len0", 64'h5000, 1'b0, 0, 4'b0000);

      // Lock
      cfg("lk.set", 1'b1, 3, 2, 64'h18, 1'b0, '0);
      cfg("lk.wbase", 1'b1, 3, 0, 64'h1234, 1'b1, 64'h0);
      cfg("lk.rbase", 1'b0, 3, 0, '0, 1'b0, 64'h0);
      cfg("lk.rattr", 1'b0, 3, 2, '0, 1'b0, 64'h18);
      cfg("lk.clr", 1'b1, 3, 2, 64'h0, 1'b1, 64'h0);
      cfg("lk.rattr2", 1'b0, 3, 2, '0, 1'b0, 64'h18);

      // Errors
      cfg("err.idx_rd", 1'b0, NR, 0, '0, 1'b1, 64'h0);
      cfg("err.idx_wr", 1'b1, 7, 1, 64'hFF, 1'b1, 64'h0);
      cfg("err.fld3", 1'b0, 0, 3, '0, 1'b1, 64'h0);

      // Backpressure: A->r1, B->r2, C miss, D->r1; 3 stalled edges while B is held
      @(negedge clk);
      lkp_valid_i = 1'b1; lkp_ready_i = 1'b1; lkp_addr = 64'h1000_0010;
      @(negedge clk);
      chk("bp.A.idx", 64'(lkp_idx), 64'd1);
      chk("bp.A.attr", 64'(lkp_attr), 64'h1);
      lkp_addr = 64'hFFFF_FFFF_FFFF_F800;
      @(negedge clk);
      chk("bp.B.idx", 64'(lkp_idx), 64'd2);
      lkp_addr = 64'h2000; lkp_ready_i = 1'b0;
      #1 chk("bp.rdy_lo", 64'(lkp_ready_o), 64'd0);
      @(negedge clk);
      chk("bp.s1.valid", 64'(lkp_valid_o), 64'd1);
      chk("bp.s1.idx", 64'(lkp_idx), 64'd2);
      cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = {3'd2, 2'd2}; cfg_wdata = 64'h0;
      @(negedge clk);
      cfg_req = 1'b0; cfg_we = 1'b0;
      chk("bp.s2.idx", 64'(lkp_idx), 64'd2);
      chk("bp.s2.attr", 64'(lkp_attr), 64'h3);
      chk("bp.s2.hit", 64'(lkp_hit), 64'd1);
      chk("bp.s2.rdy", 64'(lkp_ready_o), 64'd0);
      @(negedge clk);
      chk("bp.s3.idx", 64'(lkp_idx), 64'd2);
      chk("bp.s3.valid", 64'(lkp_valid_o), 64'd1);
      lkp_ready_i = 1'b1;
      @(negedge clk);
      chk("bp.C.valid", 64'(lkp_valid_o), 64'd1);
      chk("bp.C.hit", 64'(lkp_hit), 64'd0);
      lkp_addr = 64'h1000_0FFF;
      @(negedge clk);
      chk("bp.D.idx", 64'(lkp_idx), 64'd1);
      chk("bp.D.hit", 64'(lkp_hit), 64'd1);
      lkp_valid_i = 1'b0;
      @(negedge clk);
      chk("bp.drain", 64'(lkp_valid_o), 64'd0);
      lkp("bp.newval", 64'hFFFF_FFFF_FFFF_F800, 1'b0, 0, 4'b0000);

      // Reset drops a held result and clears lock
      @(negedge clk);
      lkp_valid_i = 1'b1; lkp_addr = 64'h1000_0010; lkp_ready_i = 1'b0;
      @(negedge clk);
      lkp_valid_i = 1'b0;
      chk("rr.held", 64'(lkp_valid_o), 64'd1);
      do_reset();
      chk("rr.dropped", 64'(lkp_valid_o), 64'd0);
      lkp_ready_i = 1'b1;
      cfg("rr.wbase", 1'b1, 3, 0, 64'h1234, 1'b0, '0);
      cfg("rr.rbase", 1'b0, 3, 0, '0, 1'b0, 64'h1234);
      cfg("rr.rattr", 1'b0, 3, 2, '0, 1'b0, 64'h0);
      lkp("rr.r1gone", 64'h1000_0010, 1'b0, 0, 4'b0000);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
